// File: rtl/dfe_pkg.sv
// Shared constants for the digital front-end chain (comb -> integrator/decimator).
// Comb and integrator both import this package so their sample and accumulator widths agree.
package dfe_pkg;

  localparam int WINDOW_LEN      = 250;
  localparam int COMB_DATA_WIDTH = 2;
  localparam int INTEG_ACC_WIDTH = 9;
  localparam int DECIM_DEFAULT   = WINDOW_LEN;
  localparam int CNT_WIDTH       = $clog2(DECIM_DEFAULT);

endpackage

// File: rtl/integrator_decim.sv
// Integrator-and-decimate stage: free-running modular accumulator of the comb output,
// emitting the running sum once every DECIMATION accepted samples.
module integrator_decim
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = COMB_DATA_WIDTH,
  parameter int ACC_WIDTH  = INTEG_ACC_WIDTH,
  parameter int DECIMATION = DECIM_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [ACC_WIDTH-1:0]  data_o,
  output logic                  valid_o
);

  // Handshake: data_i is consumed on every clock where en_i & valid_i are high (no backpressure);
  // valid_o is a single-cycle pulse and data_o is meaningful only while it is high (held otherwise).

  localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIMATION - 1);

  logic [CW-1:0]        cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] acc_next;
  logic                 acc_fire;
  logic                 cnt_last;

  // Sign extension keeps -2 (2'b10) correct even though the comb never produces it.
  assign sample_ext = {{(ACC_WIDTH - DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};
  assign acc_next   = acc + sample_ext;
  assign acc_fire   = en_i & valid_i & ~rst_i;
  assign cnt_last   = (cnt == CNT_LAST);

  // Wraps modulo 2^ACC_WIDTH; never cleared at window boundaries.
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      acc <= '0;
    end else if (acc_fire) begin
      acc <= acc_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt <= '0;
    end else if (acc_fire) begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    end
  end

  // data_o survives en_i low; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= acc_fire & cnt_last;
      if (acc_fire && cnt_last) begin
        data_o <= acc_next;
      end
    end
  end

endmodule

// File: tb/tb_integrator_decim.sv
// Bench for integrator_decim: directed scenarios then random traffic, two instances
// (9-bit and 3-bit accumulator, decimation 4) against a plain-arithmetic running-sum model.
module tb_integrator_decim;

  localparam int D  = 4;
  localparam int WA = 9;
  localparam int WB = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic [1:0]    din;
  logic          vin;
  logic [WA-1:0] data_a;
  logic          valid_a;
  logic [WB-1:0] data_b;
  logic          valid_b;

  int total;
  int bad;
  int pulses_a;

  // Reference model: integer sum and count of samples accepted since the last clear.
  int            m_sum;
  int            m_n;
  logic          m_valid;
  logic [WA-1:0] m_data_a;
  logic [WB-1:0] m_data_b;
  logic [WA-1:0] exp_q[$];

  integrator_decim #(.DATA_WIDTH(2), .ACC_WIDTH(WA), .DECIMATION(D)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vin),
    .data_o(data_a), .valid_o(valid_a)
  );

  integrator_decim #(.DATA_WIDTH(2), .ACC_WIDTH(WB), .DECIMATION(D)) dut_b (
    .clk_i(clk), .rst_i(rst), .en_i(en), .data_i(din), .valid_i(vin),
    .data_o(data_b), .valid_o(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge(input logic r, input logic e, input logic v, input int s);
    m_valid = 1'b0;
    if (r) begin
      m_sum = 0; m_n = 0; m_data_a = '0; m_data_b = '0;
    end else if (!e) begin
      m_sum = 0; m_n = 0;
    end else if (v) begin
      m_sum += s;
      m_n   += 1;
      if (m_n % D == 0) begin
        m_valid  = 1'b1;
        m_data_a = WA'(m_sum);
        m_data_b = WB'(m_sum);
        exp_q.push_back(m_data_a);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [WA-1:0] exp_pop;
    total++;
    assert (valid_a === m_valid) else begin
      bad++; $error("FAIL %s valid_a got=%b want=%b", tag, valid_a, m_valid);
    end
    total++;
    assert (data_a === m_data_a) else begin
      bad++; $error("FAIL %s data_a got=%0h want=%0h", tag, data_a, m_data_a);
    end
    total++;
    assert (valid_b === m_valid) else begin
      bad++; $error("FAIL %s valid_b got=%b want=%b", tag, valid_b, m_valid);
    end
    total++;
    assert (data_b === m_data_b) else begin
      bad++; $error("FAIL %s data_b got=%0h want=%0h", tag, data_b, m_data_b);
    end
    if (valid_a === 1'b1) begin
      pulses_a++;
      total++;
      exp_pop = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      assert (data_a === exp_pop) else begin
        bad++; $error("FAIL %s pulse_data got=%0h want=%0h", tag, data_a, exp_pop);
      end
    end
  endtask

  // One clock: apply inputs, advance model, check #1 after the edge.
  task automatic step(input string tag, input logic r, input logic e, input logic v, input int s);
    rst = r; en = e; vin = v; din = 2'(s);
    @(posedge clk);
    #1;
    model_edge(r, e, v, s);
    check_outputs(tag);
  endtask

  initial begin
    int s;
    total = 0; bad = 0; pulses_a = 0;
    m_sum = 0; m_n = 0; m_valid = 0; m_data_a = '0; m_data_b = '0;
    rst = 1'b1; en = 1'b1; vin = 1'b1; din = 2'b01;
    #2;

    // Reset held with live input.
    repeat (3) step("reset", 1'b1, 1'b1, 1'b1, 1);

    // Basic: eight +1 -> 4 then 8 (3-bit instance wraps to -4 then 0).
    for (int i = 0; i < 8; i++) step("basic", 1'b0, 1'b1, 1'b1, 1);
    step("basic_tail", 1'b0, 1'b1, 1'b0, 0);

    // Signed from a cleared accumulator: +1,-1,-1,0 -> -1; then 0,0,0,+1 -> 0.
    step("clr", 1'b0, 1'b0, 1'b0, 0);
    step("signed", 1'b0, 1'b1, 1'b1, 1);
    step("signed", 1'b0, 1'b1, 1'b1, -1);
    step("signed", 1'b0, 1'b1, 1'b1, -1);
    step("signed", 1'b0, 1'b1, 1'b1, 0);
    step("signed", 1'b0, 1'b1, 1'b1, 0);
    step("signed", 1'b0, 1'b1, 1'b1, 0);
    step("signed", 1'b0, 1'b1, 1'b1, 0);
    step("signed", 1'b0, 1'b1, 1'b1, 1);
    step("signed_tail", 1'b0, 1'b1, 1'b0, 0);

    // Bubbles: 1,0,0,1,0,1,1 -> one pulse of 4.
    step("clr", 1'b0, 1'b0, 1'b0, 0);
    pulses_a = 0;
    step("bubble", 1'b0, 1'b1, 1'b1, 1);
    step("bubble", 1'b0, 1'b1, 1'b0, 1);
    step("bubble", 1'b0, 1'b1, 1'b0, 1);
    step("bubble", 1'b0, 1'b1, 1'b1, 1);
    step("bubble", 1'b0, 1'b1, 1'b0, 1);
    step("bubble", 1'b0, 1'b1, 1'b1, 1);
    step("bubble", 1'b0, 1'b1, 1'b1, 1);
    step("bubble_tail", 1'b0, 1'b1, 1'b0, 0);
    total++;
    assert (pulses_a == 1) else begin
      bad++; $error("FAIL bubble_pulses got=%0d want=1", pulses_a);
    end

    // Enable drop mid-window: 2 x +1, en low, 4 x +1 -> 4, not 6.
    step("endrop", 1'b0, 1'b1, 1'b1, 1);
    step("endrop", 1'b0, 1'b1, 1'b1, 1);
    step("endrop_off", 1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 4; i++) step("endrop", 1'b0, 1'b1, 1'b1, 1);
    step("endrop_tail", 1'b0, 1'b1, 1'b0, 0);

    // Reset mid-window discards the partial sum.
    step("midrst", 1'b0, 1'b1, 1'b1, 1);
    step("midrst", 1'b0, 1'b1, 1'b1, 1);
    step("midrst_rst", 1'b1, 1'b1, 1'b1, 1);
    for (int i = 0; i < 5; i++) step("midrst", 1'b0, 1'b1, 1'b1, -1);

    // Random traffic including -2, bubbles, enable drops and rare resets.
    for (int i = 0; i < 400; i++) begin
      s = int'($urandom_range(0, 3)) - 2;
      step("random", ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 3) != 0), s);
    end
    step("final", 1'b0, 1'b1, 1'b0, 0);

    total++;
    assert (exp_q.size() == 0) else begin
      bad++; $error("FAIL pending_pulses got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/integrator_decim.md
Name: integrator_decim

Overview:
Integrator-and-decimate stage of the integrator-comb filter, sitting directly downstream of the comb element. It accumulates the comb's signed 2-bit difference stream into a free-running modular accumulator. Every DECIMATION accepted samples it emits one registered sample, which is the running sum (the moving-window count of ones). Its output feeds the feature-extraction stage at the decimated rate.

Parameters:
DATA_WIDTH, 2, width of signed input sample (comb output)
ACC_WIDTH, 9, width of signed accumulator and output; 9 covers the window range 0..250 for WINDOW_LEN=250
DECIMATION, 250, accepted input samples per output sample; must be >= 2

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; one clock; reset is synchronous and active-high
en_i  input  1  block enable; low synchronously clears accumulator and decimation counter
data_i  input  DATA_WIDTH  signed sample from comb (-1, 0, +1)
valid_i  input  1  data_i valid this cycle; no backpressure
data_o  output  ACC_WIDTH  signed decimated running sum
valid_o  output  1  one-cycle pulse, data_o valid

Behaviour:
- Reset (rst_i=1 at a clock edge): acc=0, cnt=0, data_o=0, valid_o=0. rst_i has priority over en_i and valid_i.
- Accept condition: acc_fire = en_i & valid_i & !rst_i. valid_i while en_i=0 is ignored.
- Accumulator: on acc_fire, acc <= acc + sign_extend(data_i) mod 2^ACC_WIDTH.
  - Two's-complement wrap is required, not saturation: CIC correctness relies on modular arithmetic.
  - acc is never cleared at decimation boundaries; it is a true integrator.
- Decimation counter: width $clog2(DECIMATION).
  - On acc_fire: if cnt==DECIMATION-1 then cnt<=0, else cnt<=cnt+1.
  - Bubbles (valid_i=0) do not advance cnt.
- Output:
  - On acc_fire with cnt==DECIMATION-1: data_o <= acc + sign_extend(data_i), the sum including the current sample, and valid_o <= 1.
  - In all other cycles valid_o <= 0.
  - Latency is 1 clock from the DECIMATION-th accepted sample to the valid_o pulse.
  - data_o holds its value between pulses.
- valid_o never asserts on two consecutive cycles, since DECIMATION>=2.
- en_i low:
  - Each cycle en_i is low: acc<=0, cnt<=0, valid_o<=0; data_o holds its last value.
  - On re-enable, counting restarts from sample 0, matching the comb FIFO, which also clears when en is low.
- Reset mid-window discards the partial window with no output pulse. The first output after reset is DECIMATION accepted samples later.
- Input values: data_i=2'b10 (-2) cannot come from the comb, but it must still be sign-extended and added correctly. No special case.
- No X-propagation: every register has an explicit reset value.

Decomposition:
- Shared package dfe_pkg holds:
  - WINDOW_LEN=250
  - COMB_DATA_WIDTH=2
  - INTEG_ACC_WIDTH=9
  - DECIMATION default = WINDOW_LEN
  - helper constant CNT_WIDTH=$clog2(DECIMATION)
- Comb and integrator both import dfe_pkg, so the widths stay consistent.
- No sub-module. Counter and accumulator are a single always block each, in one file. Target RTL size is 120-200 lines.

Test Plan:
- Reset: hold rst_i=1 for 3 cycles with valid_i=1, en_i=1, data_i=+1 -> data_o=0, valid_o=0 throughout; first pulse arrives only after DECIMATION accepted samples post-reset.
- Basic (DECIMATION=4, ACC_WIDTH=9): 8 consecutive +1 samples -> valid_o pulses 1 cycle after samples 4 and 8 with data_o=4 then 8; valid_o=0 on every other cycle.
- Signed/negative: samples +1,-1,-1,0 from acc=0 -> data_o=9'h1FF (-1); next 0,0,0,+1 -> data_o=0.
- Wraparound (ACC_WIDTH=3, DECIMATION=4): 8 samples of +1 -> data_o=3'b100 (-4) then 3'b000.
- Bubbles: valid_i pattern 1,0,0,1,0,1,1 with data_i=+1 (DECIMATION=4) -> exactly one pulse, 1 cycle after the 4th valid, data_o=4.
- Enable drop: 2 samples of +1, en_i=0 for 1 cycle, then 4 samples of +1 -> one pulse with data_o=4 (not 6); data_o keeps its prior value during en_i=0.
